// File: rtl/scan_clkgen_mp.sv
// Multi-phase programmable scan clock generator: divides RefClk by a latched ratio and
// emits NUM_PHASES registered scan clocks in free-run or counted-burst mode.
module scan_clkgen_mp #(
    parameter int unsigned NUM_PHASES = 2,
    parameter int unsigned DIV_W      = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        RefClk,
    input  logic                        Reset,
    input  logic                        ClkEn,
    input  logic                        Mode,
    input  logic                        Start,
    input  logic                        Abort,
    input  logic [DIV_W-1:0]            DivRatio,
    input  logic [DIV_W-1:0]            HighLen,
    input  logic [NUM_PHASES*DIV_W-1:0] PhaseOffset,
    input  logic [CNT_W-1:0]            BurstLen,
    output logic [NUM_PHASES-1:0]       SClk,
    output logic                        Busy,
    output logic                        Done,
    output logic                        PeriodStrobe
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                 r_state, w_state_d;
    logic [DIV_W-1:0]       r_phase_cnt, w_phase_cnt_d;
    logic [CNT_W-1:0]       r_per_cnt, w_per_cnt_d;
    logic [DIV_W-1:0]       r_div_l, r_high_l;
    logic [DIV_W-1:0]       r_off_l [NUM_PHASES];
    logic [CNT_W-1:0]       r_burst_l;
    logic [NUM_PHASES-1:0]  r_sclk, w_sclk_d;
    logic                   r_busy, r_done, r_strobe;
    logic                   w_done_d, w_strobe_d, w_start, w_run_d, w_boundary, w_exit;

    logic [DIV_W-1:0]       w_div_s, w_high_s;
    logic [DIV_W-1:0]       w_off_s [NUM_PHASES];
    logic [CNT_W-1:0]       w_burst_s;
    logic [DIV_W-1:0]       w_div_n, w_high_n;
    logic [DIV_W-1:0]       w_off_n [NUM_PHASES];
    logic [DIV_W:0]         w_dist  [NUM_PHASES];

    // Sanitised view of the raw configuration inputs, used only at the start edge.
    always_comb begin
        w_div_s  = (DivRatio < DIV_W'(2)) ? DIV_W'(2) : DivRatio;
        w_high_s = (HighLen == '0) ? DIV_W'(1) : HighLen;
        if (w_high_s > w_div_s - DIV_W'(1)) begin
            w_high_s = w_div_s - DIV_W'(1);
        end
        for (int k = 0; k < NUM_PHASES; k++) begin
            w_off_s[k] = (PhaseOffset[k*DIV_W +: DIV_W] >= w_div_s) ? '0
                                                                    : PhaseOffset[k*DIV_W +: DIV_W];
        end
        w_burst_s = (BurstLen == '0) ? CNT_W'(1) : BurstLen;
    end

    always_comb begin
        w_state_d     = r_state;
        w_phase_cnt_d = r_phase_cnt;
        w_per_cnt_d   = r_per_cnt;
        w_done_d      = 1'b0;
        w_start       = 1'b0;
        w_boundary    = (r_state == StRun) && (r_phase_cnt == r_div_l - DIV_W'(1));
        w_exit        = Abort || (!Mode && !ClkEn) ||
                        (Mode && (r_per_cnt == r_burst_l - CNT_W'(1)));
        unique case (r_state)
            StIdle: begin
                // A Start coinciding with the Done pulse belongs to the finished burst.
                if ((!Mode && ClkEn) || (Mode && Start && !r_done)) begin
                    w_start       = 1'b1;
                    w_state_d     = StRun;
                    w_phase_cnt_d = '0;
                    w_per_cnt_d   = '0;
                end
            end
            StRun: begin
                if (w_boundary) begin
                    w_phase_cnt_d = '0;
                    if (w_exit) begin
                        w_state_d   = StIdle;
                        w_done_d    = Mode;
                        w_per_cnt_d = '0;
                    end else begin
                        w_per_cnt_d = r_per_cnt + CNT_W'(1);
                    end
                end else begin
                    w_phase_cnt_d = r_phase_cnt + DIV_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are computed for the next cycle so they line up with the registered count.
    always_comb begin
        w_run_d  = (w_state_d == StRun);
        w_div_n  = w_start ? w_div_s  : r_div_l;
        w_high_n = w_start ? w_high_s : r_high_l;
        for (int k = 0; k < NUM_PHASES; k++) begin
            w_off_n[k] = w_start ? w_off_s[k] : r_off_l[k];
            if (w_phase_cnt_d >= w_off_n[k]) begin
                w_dist[k] = {1'b0, w_phase_cnt_d} - {1'b0, w_off_n[k]};
            end else begin
                w_dist[k] = {1'b0, w_phase_cnt_d} + {1'b0, w_div_n} - {1'b0, w_off_n[k]};
            end
            w_sclk_d[k] = w_run_d && (w_dist[k] < {1'b0, w_high_n});
        end
        w_strobe_d = w_run_d && (w_phase_cnt_d == w_div_n - DIV_W'(1));
    end

    always_ff @(posedge RefClk or posedge Reset) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_phase_cnt <= '0;
            r_per_cnt   <= '0;
            r_div_l     <= DIV_W'(2);
            r_high_l    <= DIV_W'(1);
            r_burst_l   <= CNT_W'(1);
            for (int k = 0; k < NUM_PHASES; k++) begin
                r_off_l[k] <= '0;
            end
            r_sclk      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_phase_cnt <= w_phase_cnt_d;
            r_per_cnt   <= w_per_cnt_d;
            if (w_start) begin
                r_div_l   <= w_div_s;
                r_high_l  <= w_high_s;
                r_burst_l <= w_burst_s;
                for (int k = 0; k < NUM_PHASES; k++) begin
                    r_off_l[k] <= w_off_s[k];
                end
            end
            r_sclk      <= w_sclk_d;
            r_busy      <= w_run_d;
            r_done      <= w_done_d;
            r_strobe    <= w_strobe_d;
        end
    end

    assign SClk         = r_sclk;
    assign Busy         = r_busy;
    assign Done         = r_done;
    assign PeriodStrobe = r_strobe;

endmodule
